// File: rtl/memcpy_pkg.sv
// Shared types and constants for the memcpy burst arbiter.
// Holds the one-hot FSM encoding and the 4KB page legality check.
package memcpy_pkg;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StIssue = 4'b0010,
        StWait  = 4'b0100,
        StResp  = 4'b1000
    } arb_state_e;

    localparam int unsigned BEAT_BYTES = 64;
    localparam int unsigned PAGE_BEATS = 64;
    localparam int unsigned PAGE_SHIFT = 12;
    localparam int unsigned BEAT_SHIFT = 6;

    // True when the burst is longer than a page or runs past the end of its 4KB page.
    function automatic logic burst_illegal(input logic [PAGE_SHIFT-BEAT_SHIFT-1:0] page_beat,
                                           input logic [7:0] len);
        logic [8:0] end_beat;
        end_beat = {3'b000, page_beat} + {1'b0, len};
        return (len > 8'(PAGE_BEATS)) || (end_beat > 9'(PAGE_BEATS));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [1:0]         idx_o,
    output logic               any_o
);

    localparam int unsigned IdxW = (NUM_REQ > 2) ? 2 : 1;

    logic [IdxW-1:0] cand;

    always_comb begin
        cand  = '0;
        idx_o = '0;
        any_o = |req_i;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IdxW'((32'(ptr_i) + 32'(i)) % NUM_REQ);
            if (req_i[cand]) begin
                idx_o = 2'(cand);
            end
        end
        gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/memcpy_burst_arbiter.sv
// Round-robin arbiter sharing one 64B-beat burst engine between NUM_REQ requesters.
// Rejects illegal bursts, issues legal ones as a start pulse and waits for done or timeout.
module memcpy_burst_arbiter
    import memcpy_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned TO_W        = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*64-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]  req_len,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  done_err,
    output logic                  eng_start,
    output logic [63:0]           eng_addr,
    output logic [7:0]            eng_len,
    input  logic                  eng_done,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  err_sticky,
    input  logic                  err_clr
);

    arb_state_e         state_q;
    logic [1:0]         ptr_q;
    logic [1:0]         grant_id_q;
    logic [63:0]        eng_addr_q;
    logic [7:0]         eng_len_q;
    logic               eng_start_q;
    logic [NUM_REQ-1:0] req_done_q;
    logic               done_err_q;
    logic               err_sticky_q;
    logic [TO_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [1:0]         pick_idx;
    logic               pick_any;
    logic [63:0]        sel_addr;
    logic [7:0]         sel_len;
    logic               sel_bad;
    logic               timeout;
    logic               err_set;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = req_addr[i*64 +: 64];
                sel_len  = req_len[i*8 +: 8];
            end
        end
        sel_bad = burst_illegal(sel_addr[PAGE_SHIFT-1:BEAT_SHIFT], sel_len);
        timeout = (state_q == StWait) && !eng_done && (cnt_q == TO_W'(TIMEOUT_CYC - 1));
        err_set = ((state_q == StIdle) && pick_any && (sel_len != 8'd0) && sel_bad) || timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            eng_addr_q   <= '0;
            eng_len_q    <= '0;
            eng_start_q  <= 1'b0;
            req_done_q   <= '0;
            done_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            eng_start_q  <= 1'b0;
            req_done_q   <= '0;
            err_sticky_q <= err_set | (err_sticky_q & ~err_clr);
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_id_q <= pick_idx;
                        eng_addr_q <= sel_addr & ~64'(BEAT_BYTES - 1);
                        eng_len_q  <= sel_len;
                        if (sel_len == 8'd0) begin
                            state_q    <= StResp;
                            req_done_q <= pick_gnt;
                            done_err_q <= 1'b0;
                        end else if (sel_bad) begin
                            state_q    <= StResp;
                            req_done_q <= pick_gnt;
                            done_err_q <= 1'b1;
                        end else begin
                            state_q     <= StIssue;
                            eng_start_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (eng_done || timeout) begin
                        state_q    <= StResp;
                        req_done_q <= NUM_REQ'(1) << grant_id_q;
                        done_err_q <= timeout;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                StResp: begin
                    ptr_q      <= (32'(grant_id_q) == NUM_REQ - 1) ? 2'd0 : grant_id_q + 2'd1;
                    done_err_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated by rst_n so no handshake can complete while the block is held in reset.
    assign req_ready  = ((state_q == StIdle) && rst_n) ? pick_gnt : '0;
    assign req_done   = req_done_q;
    assign done_err   = done_err_q;
    assign eng_start  = eng_start_q;
    assign eng_addr   = eng_addr_q;
    assign eng_len    = eng_len_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != StIdle);
    assign err_sticky = err_sticky_q;

endmodule
